// File: rtl/fifo_pkg.sv
// Shared constants and width helpers for the read-side FIFO drain logic.
package fifo_pkg;

  localparam int DSIZE_DEF = 32'sd8;

  // Bits needed to index 0..depth-1 (never less than one bit).
  function automatic int ptr_width(input int depth);
    int w;
    w = 32'sd1;
    for (int i = 32'sd1; i < 32'sd16; i++) begin
      if ((32'sd1 << i) < depth) begin
        w = i + 32'sd1;
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

  // Bits needed to hold a count of 0..depth.
  function automatic int level_width(input int depth);
    return ptr_width(depth + 32'sd1);
  endfunction

endpackage

// File: rtl/fifo_rd_buf.sv
// Circular register buffer with push/pop, occupancy count and a registered head word.
module fifo_rd_buf
  import fifo_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int DEPTH = 2,
  localparam int PW   = ptr_width(DEPTH),
  localparam int LW   = level_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [DSIZE-1:0] push_data,
  input  logic             pop,
  output logic [DSIZE-1:0] head,
  output logic [LW-1:0]    occ
);

  logic [DSIZE-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [LW-1:0]    occ_r;

  // DEPTH need not be a power of two, so wrap explicitly.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 32'sd1)) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1'b1);
    end
  endfunction

  // Storage, pointers and occupancy; a simultaneous push and pop leaves occ unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DSIZE{1'b0}};
      end
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      occ_r    <= {LW{1'b0}};
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= ptr_inc(wr_ptr_r);
      end
      if (pop) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push, pop})
        2'b10:   occ_r <= occ_r + LW'(1'b1);
        2'b01:   occ_r <= occ_r - LW'(1'b1);
        default: occ_r <= occ_r;
      endcase
    end
  end

  assign head = mem_r[rd_ptr_r];
  assign occ  = occ_r;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side drainer: pops the async FIFO into a small registered prefetch
// buffer and presents the words on a valid/ready stream.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DSIZE     = DSIZE_DEF,
  parameter int RD_LAT    = 0,
  parameter int BUF_DEPTH = 2,
  parameter int CNT_W     = 16
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             en,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DSIZE-1:0] m_data,
  output logic [2:0]       level,
  output logic [CNT_W-1:0] xfer_cnt
);

  localparam int LW = level_width(BUF_DEPTH);
  localparam logic [LW:0] DEPTH_L = (LW + 1)'(BUF_DEPTH);

  logic [LW-1:0]    occ_s;
  logic [LW:0]      pending_s;
  logic             inflight_r;
  logic             rinc_s;
  logic             push_s;
  logic             pop_s;
  logic             valid_s;
  logic [CNT_W-1:0] xfer_cnt_r;

  // Pop rule from registered state only; m_ready never reaches rinc.
  always_comb begin
    pending_s = {1'b0, occ_s} + {{LW{1'b0}}, inflight_r};
    if (rrst_n && en && !rempty && (pending_s < DEPTH_L)) begin
      rinc_s = 1'b1;
    end else begin
      rinc_s = 1'b0;
    end
  end

  // With a registered-read FIFO the word lands one edge after rinc.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      inflight_r <= 1'b0;
    end else if (RD_LAT != 32'sd0) begin
      inflight_r <= rinc_s;
    end else begin
      inflight_r <= 1'b0;
    end
  end

  assign push_s  = (RD_LAT == 32'sd0) ? rinc_s : inflight_r;
  assign valid_s = (occ_s != {LW{1'b0}});
  assign pop_s   = valid_s & m_ready;

  fifo_rd_buf #(
    .DSIZE (DSIZE),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk       (rclk),
    .rst_n     (rrst_n),
    .push      (push_s),
    .push_data (rdata),
    .pop       (pop_s),
    .head      (m_data),
    .occ       (occ_s)
  );

  // Completed-beat counter, wraps silently.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      xfer_cnt_r <= {CNT_W{1'b0}};
    end else if (pop_s) begin
      xfer_cnt_r <= xfer_cnt_r + CNT_W'(1'b1);
    end else begin
      xfer_cnt_r <= xfer_cnt_r;
    end
  end

  assign rinc     = rinc_s;
  assign m_valid  = valid_s;
  assign level    = 3'(occ_s);
  assign xfer_cnt = xfer_cnt_r;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: three instances (RD_LAT=0/depth 2, RD_LAT=1/depth 3,
// CNT_W=4) fed by a FIFO model, with a per-instance scoreboard of expected beats.
module tb_fifo_rd_stream;

  localparam int N = 3;

  logic rclk = 1'b0;
  always #5 rclk = ~rclk;

  logic         rst_n, rst2_n;
  logic [N-1:0] en, rempty, rinc, m_valid, m_ready;
  logic [7:0]   rdata  [N];
  logic [7:0]   m_data [N];
  logic [2:0]   level  [N];
  logic [15:0]  xc0, xc1;
  logic [3:0]   xc2;

  fifo_rd_stream #(.DSIZE(8), .RD_LAT(0), .BUF_DEPTH(2), .CNT_W(16)) u0 (
    .rclk(rclk), .rrst_n(rst_n), .en(en[0]), .rempty(rempty[0]), .rdata(rdata[0]),
    .rinc(rinc[0]), .m_valid(m_valid[0]), .m_ready(m_ready[0]), .m_data(m_data[0]),
    .level(level[0]), .xfer_cnt(xc0));

  fifo_rd_stream #(.DSIZE(8), .RD_LAT(1), .BUF_DEPTH(3), .CNT_W(16)) u1 (
    .rclk(rclk), .rrst_n(rst_n), .en(en[1]), .rempty(rempty[1]), .rdata(rdata[1]),
    .rinc(rinc[1]), .m_valid(m_valid[1]), .m_ready(m_ready[1]), .m_data(m_data[1]),
    .level(level[1]), .xfer_cnt(xc1));

  fifo_rd_stream #(.DSIZE(8), .RD_LAT(0), .BUF_DEPTH(2), .CNT_W(4)) u2 (
    .rclk(rclk), .rrst_n(rst2_n), .en(en[2]), .rempty(rempty[2]), .rdata(rdata[2]),
    .rinc(rinc[2]), .m_valid(m_valid[2]), .m_ready(m_ready[2]), .m_data(m_data[2]),
    .level(level[2]), .xfer_cnt(xc2));

  // FIFO model: preloaded word array, head advances on rinc
  logic [7:0] mem [N][64];
  int head   [N] = '{default: 0};
  int wr_cnt [N] = '{default: 0};
  int pops   [N] = '{default: 0};
  int beats  [N] = '{default: 0};
  int dep    [N] = '{2, 3, 2};
  logic [7:0] rd1_r = 8'h00;
  logic       pend1 = 1'b0;

  logic [7:0] exp0[$];
  logic [7:0] exp1[$];
  logic [7:0] exp2[$];

  int vectors = 0;
  int miscompares = 0;

  always_comb begin
    for (int k = 0; k < N; k++) rempty[k] = (head[k] >= wr_cnt[k]);
    rdata[0] = mem[0][head[0][5:0]];
    rdata[1] = rd1_r;
    rdata[2] = mem[2][head[2][5:0]];
  end

  always @(posedge rclk) begin
    for (int k = 0; k < N; k++) begin
      if (rinc[k]) begin
        head[k] <= head[k] + 1;
        pops[k] <= pops[k] + 1;
      end
    end
    if (rinc[1]) rd1_r <= mem[1][head[1][5:0]];
    pend1 <= rinc[1];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int k, input logic [7:0] v);
    mem[k][wr_cnt[k][5:0]] = v;
    wr_cnt[k] = wr_cnt[k] + 1;
    case (k)
      0: exp0.push_back(v);
      1: exp1.push_back(v);
      default: exp2.push_back(v);
    endcase
  endtask

  // Scoreboard and buffer-overflow check, sampled on the falling edge
  task automatic monitor();
    logic [7:0] e;
    int sz;
    logic cap;
    for (int k = 0; k < N; k++) begin
      if (m_valid[k] && m_ready[k]) begin
        beats[k]++;
        sz = (k == 0) ? exp0.size() : (k == 1) ? exp1.size() : exp2.size();
        check($sformatf("u%0d_beat_expected", k), (sz != 0), 1);
        if (sz != 0) begin
          case (k)
            0: e = exp0.pop_front();
            1: e = exp1.pop_front();
            default: e = exp2.pop_front();
          endcase
          check($sformatf("u%0d_beat%0d_data", k, beats[k]), m_data[k], e);
        end
      end
      cap = (k == 1) ? pend1 : rinc[k];
      if (cap) begin
        check($sformatf("u%0d_capture_not_full", k),
              (level[k] == 3'(dep[k])) && !(m_valid[k] && m_ready[k]), 0);
      end
    end
    if (pend1) check("u1_inflight_room", (int'(level[1]) + 1) <= 3, 1);
  endtask

  task automatic tick();
    @(negedge rclk);
    monitor();
    @(posedge rclk);
    #1;
  endtask

  initial begin
    int base, b3;
    rst_n = 1'b0; rst2_n = 1'b0; en = '1; m_ready = '0;
    load(2, 8'd1);
    #1;
    check("u2_rinc_in_reset", rinc[2], 0);
    repeat (3) tick();
    rst_n = 1'b1; rst2_n = 1'b1;
    tick();
    check("u0_rst_rinc", rinc[0], 0);
    check("u0_rst_valid", m_valid[0], 0);
    check("u0_rst_level", level[0], 0);
    check("u0_rst_xfer", xc0, 0);
    check("u1_rst_valid", m_valid[1], 0);

    // Streaming 0x01..0x10 at full rate
    m_ready[0] = 1'b1;
    for (int i = 1; i <= 16; i++) load(0, 8'(i));
    #1;
    check("u0_first_rinc", rinc[0], 1);
    check("u0_first_valid_early", m_valid[0], 0);
    tick();
    check("u0_first_data", m_data[0], 8'h01);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("u0_nobubble%0d", i), m_valid[0], 1);
      tick();
    end
    check("u0_stream_xfer", xc0, 16);
    check("u0_stream_drained", m_valid[0], 0);

    // Backpressure: only BUF_DEPTH pops while m_ready is low
    m_ready[0] = 1'b0;
    for (int i = 1; i <= 6; i++) load(0, 8'(i));
    base = pops[0];
    repeat (10) tick();
    check("u0_bp_pops", pops[0] - base, 2);
    check("u0_bp_level", level[0], 2);
    check("u0_bp_hold_data", m_data[0], 8'h01);
    check("u0_bp_rinc", rinc[0], 0);
    m_ready[0] = 1'b1;
    for (int t = 0; t < 20 && beats[0] < 22; t++) tick();
    check("u0_bp_beats", beats[0], 22);

    // en dropped after the third beat
    for (int i = 1; i <= 10; i++) load(0, 8'(i));
    base = beats[0];
    for (int t = 0; t < 20 && beats[0] < base + 3; t++) tick();
    check("u0_en_third", beats[0] - base, 3);
    en[0] = 1'b0;
    b3 = beats[0];
    repeat (6) tick();
    check("u0_en_extra_le", (beats[0] - b3) <= 2, 1);
    check("u0_en_valid_low", m_valid[0], 0);
    check("u0_en_rinc_low", rinc[0], 0);
    en[0] = 1'b1;
    for (int t = 0; t < 30 && beats[0] < base + 10; t++) tick();
    check("u0_en_resume_beats", beats[0] - base, 10);

    // RD_LAT=1, BUF_DEPTH=3 with toggling ready
    for (int i = 0; i < 8; i++) load(1, 8'hA0 + 8'(i));
    #1;
    check("u1_first_rinc", rinc[1], 1);
    check("u1_first_valid0", m_valid[1], 0);
    tick();
    check("u1_valid_lat1", m_valid[1], 0);
    tick();
    check("u1_valid_lat2", m_valid[1], 1);
    check("u1_first_data", m_data[1], 8'hA0);
    for (int t = 0; t < 60 && beats[1] < 8; t++) begin
      m_ready[1] = ~m_ready[1];
      tick();
    end
    m_ready[1] = 1'b1;
    tick();
    check("u1_beats", beats[1], 8);
    check("u1_drained_level", level[1], 0);
    check("u1_xfer", xc1, 8);

    // Counter wrap at CNT_W=4, then asynchronous reset mid-burst
    m_ready[2] = 1'b1;
    for (int i = 2; i <= 20; i++) load(2, 8'(i));
    for (int t = 0; t < 40 && beats[2] < 20; t++) tick();
    check("u2_beats20", beats[2], 20);
    check("u2_xfer_wrap", xc2, 4);
    for (int i = 0; i < 10; i++) load(2, 8'h21 + 8'(i));
    for (int t = 0; t < 20 && beats[2] < 23; t++) tick();
    check("u2_pre_rst_valid", m_valid[2], 1);
    #2;
    rst2_n = 1'b0;
    #1;
    check("u2_rst_valid", m_valid[2], 0);
    check("u2_rst_data", m_data[2], 0);
    check("u2_rst_level", level[2], 0);
    check("u2_rst_xfer", xc2, 0);
    check("u2_rst_rinc", rinc[2], 0);
    exp2.delete();
    tick();
    check("u0_sb_empty", exp0.size(), 0);
    check("u1_sb_empty", exp1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Read-side drainer for the async FIFO; sits entirely in the read clock domain.
- Pops words through rinc/rempty/rdata and presents them on a valid/ready stream via a small registered prefetch buffer.
- m_valid and m_data are registered; no combinational path from m_ready to rinc.

Parameters:
- DSIZE, 8: data width; must match the FIFO DSIZE.
- RD_LAT, 0: FIFO read latency. 0 means rdata shows the head word whenever rempty=0. 1 means rdata is valid the cycle after rinc.
- BUF_DEPTH, 2: prefetch buffer entries. Legal range is 2..4. Full throughput requires BUF_DEPTH >= 2+RD_LAT.
- CNT_W, 16: width of the transferred-word counter.

Ports:
- rclk  input  1  read-domain clock.
- rrst_n  input  1  asynchronous active-low reset.
- en  input  1  prefetch enable; low stops new pops, but buffered words still drain.
- rempty  input  1  FIFO empty flag.
- rdata  input  DSIZE  FIFO read data.
- rinc  output  1  FIFO pop strobe.
- m_valid  output  1  stream data valid.
- m_ready  input  1  stream consumer ready.
- m_data  output  DSIZE  stream data (buffer head).
- level  output  3  buffered-word count, 0..BUF_DEPTH.
- xfer_cnt  output  CNT_W  count of completed stream beats; wraps modulo 2^CNT_W.

Behaviour:
- Clock and reset: one clock, rclk. Reset rrst_n is asynchronous, active-low.
- Reset values:
  - occupancy = 0, in-flight = 0, rd/wr pointers = 0.
  - m_valid = 0, m_data = 0, level = 0, xfer_cnt = 0.
  - rinc = 0 while rrst_n = 0.
- Pop rule: rinc = en & ~rempty & (occ + inflight < BUF_DEPTH).
  - Uses registered state only; never depends on m_ready.
- Capture:
  - RD_LAT=0: on a cycle with rinc=1, rdata is written into the buffer at that edge.
  - RD_LAT=1: an in-flight flag sets on rinc. rdata is written on the following edge, and the flag clears unless rinc is also high that cycle.
  - At most 1 read is in flight.
- Pop from stream: fires when m_valid & m_ready. Read pointer advances and xfer_cnt increments by 1 at that edge.
- Simultaneous capture and stream pop in one cycle: occupancy is unchanged; both pointers advance; the data order is preserved.
- m_valid = (occ != 0), registered. m_data = buffer[rd_ptr], taken from registered storage.
- Stream rule: once m_valid is 1, m_valid and m_data stay stable until a handshake occurs.
- Pointers wrap modulo BUF_DEPTH. occ saturates conceptually at BUF_DEPTH.
- A capture while occ = BUF_DEPTH with no simultaneous pop is a design error; the bench asserts it never happens.
- Throughput: with BUF_DEPTH = 2+RD_LAT, sustained 1 word/cycle when rempty=0 and m_ready=1.
- Latency:
  - First word: m_valid rises 1 cycle after the rinc edge for RD_LAT=0, and 2 cycles after for RD_LAT=1.
- en falling with a read in flight: the in-flight word is still captured; no new rinc is issued.
- rempty rising mid-stream: rinc drops the same cycle; buffered words drain normally.
- Reset mid-operation: buffered and in-flight words are discarded. A popped-but-uncaptured word is lost, which is acceptable because the FIFO is reset in the same domain.
- xfer_cnt wraps from 2^CNT_W-1 to 0 with no flag.

Decomposition:
- fifo_pkg holds:
  - DSIZE default.
  - Function clog2-style pointer width for BUF_DEPTH.
  - Function deriving the level width.
- One sub-module, fifo_rd_buf: parameterised circular register buffer with push/pop, occ, and head output.
- The top level owns the pop rule, the in-flight tracking and xfer_cnt.

Test Plan:
- Reset, RD_LAT=0: hold rempty=1, then release reset → rinc=0, m_valid=0, level=0, xfer_cnt=0.
- Streaming: FIFO preloaded with 0x01..0x10, m_ready=1 → 16 beats on consecutive cycles, values in order, xfer_cnt=16, no bubbles after the first beat.
- Backpressure: m_ready=0 for 10 cycles with FIFO non-empty → exactly BUF_DEPTH pops, level=2, m_data held at 0x01; release m_ready → order intact.
- RD_LAT=1 with BUF_DEPTH=3: 8 words, m_ready toggling 1,0,1,0 → all 8 words are delivered in order, never more than 1 read is in flight, and no capture occurs while the buffer is full.
- en low during streaming: drop en after the 3rd beat → at most BUF_DEPTH+RD_LAT further beats, then m_valid=0; raise en → streaming resumes with the next sequential value.
- Wrap and reset: CNT_W=4, 20 beats → xfer_cnt=4; assert rrst_n low mid-burst → all outputs return to 0 within the same cycle (asynchronous).
